// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use bubbles, memory-busy freeze, branch squash.
// Optional STALL_CNT_EN builds a saturating stalled-cycle counter on stall_count.
module hazard_stall_unit #(
  parameter int BUBBLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [6:0]  id_ctrl,
  input  logic        ex_memread,
  input  logic [2:0]  ex_rd,
  input  logic        mem_stall,
  input  logic        br_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic [6:0]  idex_ctrl,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {RUN, BUBBLE, FREEZE} state_t;

  localparam logic [1:0] BUB_LOAD = 2'(BUBBLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] bub_cnt, bub_cnt_nxt;
  logic       flush_pend, flush_pend_nxt;
  logic       hazard;

  assign hazard = ex_memread & ((id_uses_rs & (id_rs == ex_rd)) |
                                (id_uses_rt & (id_rt == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      bub_cnt    <= 2'd0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      bub_cnt    <= bub_cnt_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  always_comb begin
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    ifid_flush     = 1'b0;
    idex_en        = 1'b1;
    idex_ctrl      = id_ctrl;
    state_nxt      = RUN;
    bub_cnt_nxt    = bub_cnt;
    flush_pend_nxt = flush_pend;

    if (rst) begin
      pc_en          = 1'b0;
      ifid_en        = 1'b0;
      ifid_flush     = 1'b1;
      idex_ctrl      = 7'h00;
      bub_cnt_nxt    = 2'd0;
      flush_pend_nxt = 1'b0;
    end else if (mem_stall) begin
      // Everything holds; a branch resolved now is squashed on release.
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      state_nxt = FREEZE;
      if (br_taken) flush_pend_nxt = 1'b1;
    end else if (br_taken || flush_pend) begin
      ifid_flush     = 1'b1;
      idex_ctrl      = 7'h00;
      bub_cnt_nxt    = 2'd0;
      flush_pend_nxt = 1'b0;
    end else if (state == BUBBLE || (state == FREEZE && bub_cnt != 2'd0)) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_ctrl   = 7'h00;
      bub_cnt_nxt = bub_cnt - 2'd1;
      state_nxt   = (bub_cnt == 2'd1) ? RUN : BUBBLE;
    end else if (hazard) begin
      // First bubble is issued this cycle; the counter tracks the rest.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_ctrl   = 7'h00;
      bub_cnt_nxt = BUB_LOAD;
      state_nxt   = (BUBBLE_CYCLES > 1) ? BUBBLE : RUN;
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if (!pc_en && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: BUBBLE_CYCLES=1 and =3 instances on shared stimulus,
// each checked every cycle against a pending-work model plus literal expectations.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memread, mem_stall, br_taken;
  logic [6:0] id_ctrl;

  logic [1:0]  pc_en_w, ifid_en_w, ifid_flush_w, idex_en_w;
  logic [6:0]  idex_ctrl_w [2];
  logic [15:0] stall_count_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  // model state: bubbles still owed, deferred flush, stalled-cycle count
  int rem  [2];
  bit pend [2];
  int cnt  [2];
  int bc   [2] = '{1, 3};

  always #5 clk = ~clk;

  hazard_stall_unit #(.BUBBLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_stall(mem_stall),
    .br_taken(br_taken), .pc_en(pc_en_w[0]), .ifid_en(ifid_en_w[0]),
    .ifid_flush(ifid_flush_w[0]), .idex_en(idex_en_w[0]),
    .idex_ctrl(idex_ctrl_w[0]), .stall_count(stall_count_w[0])
  );

  hazard_stall_unit #(.BUBBLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_stall(mem_stall),
    .br_taken(br_taken), .pc_en(pc_en_w[1]), .ifid_en(ifid_en_w[1]),
    .ifid_flush(ifid_flush_w[1]), .idex_en(idex_en_w[1]),
    .idex_ctrl(idex_ctrl_w[1]), .stall_count(stall_count_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard_m();
    return ex_memread && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_ctrl}
  function automatic logic [10:0] model_out(int k);
    if (rst)                    return {4'b0011, 7'h00};
    if (mem_stall)              return {4'b0000, id_ctrl};
    if (br_taken || pend[k])    return {4'b1111, 7'h00};
    if (rem[k] > 0 || hazard_m()) return {4'b0001, 7'h00};
    return {4'b1101, id_ctrl};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [10:0] e;
      e = model_out(k);
      if (rst) begin
        rem[k] = 0; pend[k] = 1'b0; cnt[k] = 0;
      end else begin
        if (!e[10] && cnt[k] < 65535) cnt[k]++;
        if (mem_stall) begin
          if (br_taken) pend[k] = 1'b1;
        end else if (br_taken || pend[k]) begin
          rem[k] = 0; pend[k] = 1'b0;
        end else if (rem[k] > 0) begin
          rem[k]--;
        end else if (hazard_m()) begin
          rem[k] = bc[k] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [10:0] e;
      int          ecnt;
      e = model_out(k);
`ifdef STALL_CNT_EN
      ecnt = cnt[k];
`else
      ecnt = 0;
`endif
      chk($sformatf("pc_en[%0d]", k),      pc_en_w[k],       e[10]);
      chk($sformatf("ifid_en[%0d]", k),    ifid_en_w[k],     e[9]);
      chk($sformatf("ifid_flush[%0d]", k), ifid_flush_w[k],  e[8]);
      chk($sformatf("idex_en[%0d]", k),    idex_en_w[k],     e[7]);
      chk($sformatf("idex_ctrl[%0d]", k),  idex_ctrl_w[k],   e[6:0]);
      chk($sformatf("stall_cnt[%0d]", k),  stall_count_w[k], ecnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0; br_taken = 1'b0; ex_memread = 1'b0;
    ex_rd = 3'd0; id_rs = 3'd0; id_rt = 3'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_ctrl = 7'h5A;
    #1;
    chk("lit_rst_pc_en", pc_en_w[0], 1'b0);
    chk("lit_rst_flush", ifid_flush_w[0], 1'b1);
    chk("lit_rst_ctrl", idex_ctrl_w[1], 7'h00);
    tick(); tick();
    rst = 1'b0; #1;
    chk("lit_run_pc_en", pc_en_w[0], 1'b1);
    chk("lit_run_ctrl", idex_ctrl_w[0], 7'h5A);
    tick();

    // load-use hazard on rs
    ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1; id_ctrl = 7'h21; #1;
    chk("lit_hz1_pc_en", pc_en_w[0], 1'b0);
    chk("lit_hz1_ifid_en", ifid_en_w[0], 1'b0);
    chk("lit_hz1_ctrl", idex_ctrl_w[0], 7'h00);
    chk("lit_hz3_b1", pc_en_w[1], 1'b0);
    tick(); ex_memread = 1'b0; #1;
    chk("lit_hz1_after", idex_ctrl_w[0], 7'h21);
    chk("lit_hz3_b2", idex_ctrl_w[1], 7'h00);
    tick(); #1;
    chk("lit_hz3_b3", pc_en_w[1], 1'b0);
    tick(); #1;
    chk("lit_hz3_done", idex_ctrl_w[1], 7'h21);
    ex_memread = 1'b1; id_uses_rs = 1'b0; #1;
    chk("lit_nouse_u1", pc_en_w[0], 1'b1);
    chk("lit_nouse_u3", pc_en_w[1], 1'b1);
    tick();

    // R0 participates like any register
    ex_rd = 3'd0; id_rt = 3'd0; id_uses_rt = 1'b1; id_rs = 3'd5; #1;
    chk("lit_r0_hz", pc_en_w[0], 1'b0);
    tick(); ex_memread = 1'b0; id_uses_rt = 1'b0;
    tick(); tick();

    // freeze with a branch in its 2nd cycle
    id_ctrl = 7'h4C; mem_stall = 1'b1; #1;
    chk("lit_frz_pc_en", pc_en_w[0], 1'b0);
    chk("lit_frz_idex_en", idex_en_w[0], 1'b0);
    tick(); br_taken = 1'b1; #1;
    chk("lit_frz_br_ifid", ifid_en_w[1], 1'b0);
    chk("lit_frz_br_flush", ifid_flush_w[0], 1'b0);
    tick(); br_taken = 1'b0; #1;
    chk("lit_frz3_idex_en", idex_en_w[0], 1'b0);
    tick(); mem_stall = 1'b0; #1;
    chk("lit_rel_flush", ifid_flush_w[0], 1'b1);
    chk("lit_rel_ctrl", idex_ctrl_w[1], 7'h00);
    tick(); #1;
    chk("lit_rel_next", idex_ctrl_w[0], 7'h4C);
    chk("lit_rel_next_fl", ifid_flush_w[1], 1'b0);

    // freeze lands in the middle of a 3-bubble sequence
    id_ctrl = 7'h33; ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1; #1;
    chk("lit_mid_b1", pc_en_w[1], 1'b0);
    tick(); ex_memread = 1'b0; #1;
    chk("lit_mid_b2", idex_ctrl_w[1], 7'h00);
    tick(); mem_stall = 1'b1; tick(); tick(); mem_stall = 1'b0; #1;
    chk("lit_mid_last", idex_ctrl_w[1], 7'h00);
    chk("lit_mid_u1", pc_en_w[0], 1'b1);
    tick(); #1;
    chk("lit_mid_done", idex_ctrl_w[1], 7'h33);

    // taken branch cancels owed bubbles
    ex_memread = 1'b1; tick(); ex_memread = 1'b0; br_taken = 1'b1; #1;
    chk("lit_cancel_fl", ifid_flush_w[1], 1'b1);
    tick(); br_taken = 1'b0; #1;
    chk("lit_cancel_run", pc_en_w[1], 1'b1);

    // reset discards a deferred flush and owed bubbles
    mem_stall = 1'b1; br_taken = 1'b1; tick(); br_taken = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; mem_stall = 1'b0; #1;
    chk("lit_rst_nopend", ifid_flush_w[0], 1'b0);
    ex_memread = 1'b1; tick(); ex_memread = 1'b0; rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("lit_rst_nobub", pc_en_w[1], 1'b1);

    // five stalled cycles after reset
    rst = 1'b1; tick(); rst = 1'b0; mem_stall = 1'b1;
    repeat (5) tick();
    mem_stall = 1'b0; #1;
`ifdef STALL_CNT_EN
    chk("lit_cnt5", stall_count_w[0], 16'd5);
`else
    chk("lit_cnt0", stall_count_w[0], 16'd0);
`endif
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

- Pipeline hazard and stall controller.
- Drives the pipeline enables for the PC, IF/ID and ID/EX registers.
- Produces the 7-bit ID/EX control bundle consumed directly by the downstream 7-bit enabled control register.
- Handles three hazard types:
  - inserts load-use bubbles;
  - freezes the front end while data memory is busy;
  - squashes the wrong-path instruction on a taken branch.
- A taken branch that arrives during a freeze is remembered and applied when the freeze releases.

## Interface
Parameters:
- BUBBLE_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_rs  in  3  source register A of the instruction in ID.
- id_rt  in  3  source register B of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads id_rs.
- id_uses_rt  in  1  ID instruction reads id_rt.
- id_ctrl  in  7  decoded control bundle of the ID instruction.
- ex_memread  in  1  the instruction in EX is a load.
- ex_rd  in  3  destination register of the EX instruction.
- mem_stall  in  1  data memory busy; the pipeline must hold.
- br_taken  in  1  branch/jump resolved taken this cycle.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX register enable; feeds the 7-bit control register's en.
- idex_ctrl  out  7  next ID/EX control bundle; 7'h00 = bubble.
- stall_count  out  16  stalled-cycle counter (see Configuration).

## Operation
State:
- States: RUN, BUBBLE, FREEZE.
- bub_cnt: 2-bit counter.
- flush_pend: 1-bit flag.
- Reset values: state=RUN, bub_cnt=0, flush_pend=0, stall_count=0.

Hazard condition:
- hazard = ex_memread & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- R0 is an ordinary register; there is no zero-register exclusion.

Per-cycle behaviour, in strict priority order:
1. rst=1:
   - outputs pc_en=0, ifid_en=0, ifid_flush=1, idex_en=1, idex_ctrl=7'h00;
   - next state is the reset state.
2. mem_stall=1 (any state):
   - outputs pc_en=ifid_en=idex_en=0, ifid_flush=0, idex_ctrl=id_ctrl;
   - next state FREEZE; bub_cnt holds;
   - if br_taken=1, flush_pend is set.
3. Flush, when br_taken|flush_pend and mem_stall=0:
   - outputs pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_ctrl=7'h00;
   - next state RUN; bub_cnt=0; flush_pend=0.
   - A flush cancels any pending bubbles.
4. Bubble, when in BUBBLE, or FREEZE with bub_cnt≠0:
   - outputs pc_en=0, ifid_en=0, ifid_flush=0, idex_en=1, idex_ctrl=7'h00;
   - bub_cnt decrements; state RUN when bub_cnt==1, else BUBBLE;
   - hazard is ignored in this step.
5. New hazard, in RUN, or FREEZE with bub_cnt=0:
   - outputs are the same as Bubble;
   - bub_cnt loads BUBBLE_CYCLES-1; next state BUBBLE if BUBBLE_CYCLES>1, else RUN.
6. Otherwise:
   - outputs pc_en=1, ifid_en=1, ifid_flush=0, idex_en=1, idex_ctrl=id_ctrl;
   - next state RUN.

Freeze release:
- On the first cycle with mem_stall=0, FREEZE resolves through rules 3–6.
- This resumes the interrupted bubble sequence or applies the pending flush.

## Timing
- All outputs are combinational from the current inputs, state, bub_cnt and flush_pend. No output register.
- Hazard response is zero-latency: the bubble appears on idex_ctrl in the same cycle the hazard is presented.
- One load-use hazard yields exactly BUBBLE_CYCLES consecutive bubble cycles, excluding any interleaved freeze cycles.
- A freeze has no fixed length; it lasts exactly as many cycles as mem_stall is high.
- A deferred branch flush is applied on the release cycle and never later.
- Reset mid-bubble or mid-freeze drops all pending work, including any pending flush.

## Configuration
- Macro: STALL_CNT_EN.
- Defined:
  - stall_count increments on every rising edge where rst=0 and pc_en=0;
  - it saturates at 16'hFFFF and clears on rst.
- Undefined:
  - the stall_count port remains present, tied to 16'h0000;
  - no counter flops are built.

## Test plan
- Reset for 2 cycles → pc_en=0, ifid_flush=1, idex_ctrl=7'h00. Then release with id_ctrl=7'h5A and no hazard → pc_en=1, idex_ctrl=7'h5A.
- BUBBLE_CYCLES=1, ex_memread=1, ex_rd=3, id_rs=3, id_uses_rs=1 → one cycle with pc_en=ifid_en=0, idex_ctrl=7'h00, then normal. Same stimulus with id_uses_rs=0 → no stall.
- BUBBLE_CYCLES=3, single-cycle hazard pulse → exactly 3 bubble cycles, then idex_ctrl=id_ctrl.
- mem_stall high for 3 cycles with br_taken pulsed in the 2nd → all enables 0 for 3 cycles. Release cycle: ifid_flush=1, idex_ctrl=7'h00. Then normal.
- BUBBLE_CYCLES=3, mem_stall asserted 2 cycles after the hazard cycle → after release, exactly 1 remaining bubble.
- STALL_CNT_EN defined, 5 stalled cycles after reset → stall_count=16'd5. Undefined → stall_count stays 16'h0000.
